nv_nvdla_glb_intr_arb: RTL and testbench

NV_NVDLA_GLB_INTR_ARB -- requirements
Module: NV_NVDLA_GLB_intr_arb

---
 rtl/nv_nvdla_glb_intr_arb_pkg.sv | 55 +++++
 rtl/nv_nvdla_glb_intr_arb_fifo.sv | 51 +++++
 rtl/nv_nvdla_glb_intr_arb.sv | 103 ++++++++++
 tb/tb_nv_nvdla_glb_intr_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_glb_intr_arb_pkg.sv
// Shared GLB interrupt constants, source-index encoding, event record and
// the round-robin pick helper used by the arbiter.
package nv_nvdla_glb_intr_arb_pkg;

    localparam int NUM_SRC    = 12;
    localparam int FIFO_DEPTH = 8;
    localparam int TS_W       = 16;
    localparam int OVF_W      = 8;
    localparam int ID_W       = 4;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;

    // Source index = 2*unit + group.
    typedef enum logic [ID_W-1:0] {
        SRC_SDP_G0      = 4'd0,
        SRC_SDP_G1      = 4'd1,
        SRC_CDP_G0      = 4'd2,
        SRC_CDP_G1      = 4'd3,
        SRC_PDP_G0      = 4'd4,
        SRC_PDP_G1      = 4'd5,
        SRC_CDMA_DAT_G0 = 4'd6,
        SRC_CDMA_DAT_G1 = 4'd7,
        SRC_CDMA_WT_G0  = 4'd8,
        SRC_CDMA_WT_G1  = 4'd9,
        SRC_CACC_G0     = 4'd10,
        SRC_CACC_G1     = 4'd11
    } src_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
    } evt_t;

    // Lowest requesting index at or above ptr, wrapping modulo NUM_SRC.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx4;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            idx4 = idx[ID_W-1:0];
            if (!found && req[idx4]) begin
                found = 1'b1;
                pick  = idx4;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/nv_nvdla_glb_intr_arb_fifo.sv
// 8-entry flop-based event FIFO with valid/ready pop and synchronous flush.
// Head data is forced to zero whenever the FIFO is empty or in reset.
module nv_nvdla_glb_intr_arb_fifo
    import nv_nvdla_glb_intr_arb_pkg::*;
(
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  evt_t             i_push_data,
    output logic             o_valid,
    input  logic             i_ready,
    output evt_t             o_data,
    output logic [CNT_W-1:0] o_cnt
);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    evt_t             r_mem [FIFO_DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_valid = (r_cnt != '0);
    assign o_cnt   = r_cnt;
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_push && (r_cnt < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_push_data;
    end

endmodule

// File: rtl/nv_nvdla_glb_intr_arb.sv
// GLB done-interrupt arbiter: pending bits, round-robin grant into an event
// FIFO with timestamps, and lost-event (overflow) accounting.
module nv_nvdla_glb_intr_arb
    import nv_nvdla_glb_intr_arb_pkg::*;
(
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic [NUM_SRC-1:0] done_pd,
    input  logic               arb_en,
    input  logic               evt_flush,
    input  logic               ovf_clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ID_W-1:0]    evt_id,
    output logic [TS_W-1:0]    evt_ts,
    output logic [CNT_W-1:0]   fifo_cnt,
    output logic [NUM_SRC-1:0] ovf_sticky,
    output logic [OVF_W-1:0]   ovf_cnt
);

    logic [NUM_SRC-1:0] r_pend;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [TS_W-1:0]    r_ts_cnt;
    logic [NUM_SRC-1:0] r_ovf_sticky;
    logic [OVF_W-1:0]   r_ovf_cnt;

    logic               w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic [NUM_SRC-1:0] w_gnt_oh;
    logic [NUM_SRC-1:0] w_lost;
    logic [ID_W-1:0]    w_loss_num;
    logic [OVF_W:0]     w_ovf_sum;
    logic [CNT_W-1:0]   w_fifo_cnt;
    evt_t               w_push_evt;
    evt_t               w_head;

    // Uses the registered count, so a same-cycle pop never opens a slot.
    assign w_gnt      = arb_en && (|r_pend) && (w_fifo_cnt < CNT_W'(FIFO_DEPTH)) && !evt_flush;
    assign w_gnt_id   = rr_pick(r_pend, r_rr_ptr);
    assign w_gnt_oh   = w_gnt ? (NUM_SRC'(1) << w_gnt_id) : '0;
    assign w_lost     = evt_flush ? '0 : (done_pd & r_pend & ~w_gnt_oh);
    assign w_push_evt = '{id: w_gnt_id, ts: r_ts_cnt};

    always_comb begin
        w_loss_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_lost[i]) w_loss_num = w_loss_num + ID_W'(1);
        end
        w_ovf_sum = {1'b0, r_ovf_cnt} + (OVF_W+1)'(w_loss_num);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_pend   <= '0;
            r_rr_ptr <= '0;
        end else if (evt_flush) begin
            r_pend   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_pend <= (r_pend & ~w_gnt_oh) | done_pd;
            if (w_gnt) begin
                r_rr_ptr <= (w_gnt_id == ID_W'(NUM_SRC-1)) ? '0 : w_gnt_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) r_ts_cnt <= '0;
        else                  r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_ovf_sticky <= '0;
            r_ovf_cnt    <= '0;
        end else if (ovf_clr) begin
            r_ovf_sticky <= '0;
            r_ovf_cnt    <= '0;
        end else begin
            r_ovf_sticky <= r_ovf_sticky | w_lost;
            r_ovf_cnt    <= w_ovf_sum[OVF_W] ? '1 : w_ovf_sum[OVF_W-1:0];
        end
    end

    nv_nvdla_glb_intr_arb_fifo u_fifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_flush         (evt_flush),
        .i_push          (w_gnt),
        .i_push_data     (w_push_evt),
        .o_valid         (evt_valid),
        .i_ready         (evt_ready),
        .o_data          (w_head),
        .o_cnt           (w_fifo_cnt)
    );

    assign evt_id     = w_head.id;
    assign evt_ts     = w_head.ts;
    assign fifo_cnt   = w_fifo_cnt;
    assign ovf_sticky = r_ovf_sticky;
    assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_nv_nvdla_glb_intr_arb.sv
// Directed bench for the GLB interrupt arbiter with hand-computed expectations.
module tb_nv_nvdla_glb_intr_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [11:0] done_pd = '0;
    logic        arb_en = 1'b0;
    logic        evt_flush = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        evt_ready = 1'b0;
    logic        evt_valid;
    logic [3:0]  evt_id;
    logic [15:0] evt_ts;
    logic [3:0]  fifo_cnt;
    logic [11:0] ovf_sticky;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;

    nv_nvdla_glb_intr_arb dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .done_pd         (done_pd),
        .arb_en          (arb_en),
        .evt_flush       (evt_flush),
        .ovf_clr         (ovf_clr),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_id          (evt_id),
        .evt_ts          (evt_ts),
        .fifo_cnt        (fifo_cnt),
        .ovf_sticky      (ovf_sticky),
        .ovf_cnt         (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] v);
        done_pd = v;
        tick();
        done_pd = '0;
    endtask

    task automatic flush_all();
        evt_flush = 1'b1;
        tick();
        evt_flush = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_ts", 32'(evt_ts), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
        chk("rst_pend", 32'(dut.r_pend), 32'd0);

        // First event after reset: ts_cnt is 1 in the grant cycle.
        done_pd = 12'h001;
        arb_en  = 1'b1;
        rstn    = 1'b1;
        tick();
        done_pd = '0;
        chk("lat_pend", 32'(dut.r_pend), 32'h001);
        chk("lat_valid0", 32'(evt_valid), 32'd0);
        tick();
        chk("lat_valid1", 32'(evt_valid), 32'd1);
        chk("lat_id", 32'(evt_id), 32'd0);
        chk("lat_ts", 32'(evt_ts), 32'd1);
        chk("lat_cnt", 32'(fifo_cnt), 32'd1);
        tick();
        chk("hold_id", 32'(evt_id), 32'd0);
        chk("hold_ts", 32'(evt_ts), 32'd1);
        evt_ready = 1'b1;
        tick();
        chk("pop_valid", 32'(evt_valid), 32'd0);

        // All twelve pending with a free-flowing consumer.
        flush_all();
        pulse(12'hFFF);
        chk("all_pend", 32'(dut.r_pend), 32'hFFF);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rr_valid%0d", k), 32'(evt_valid), 32'd1);
            chk($sformatf("rr_id%0d", k), 32'(evt_id), 32'(k));
        end
        tick();
        chk("rr_done_valid", 32'(evt_valid), 32'd0);
        chk("rr_done_pend", 32'(dut.r_pend), 32'd0);

        // Back-pressure: FIFO fills at 8, four sources stay pending.
        evt_ready = 1'b0;
        pulse(12'hFFF);
        repeat (8) tick();
        chk("full_cnt", 32'(fifo_cnt), 32'd8);
        chk("full_pend", 32'(dut.r_pend), 32'hF00);
        repeat (2) tick();
        chk("stall_cnt", 32'(fifo_cnt), 32'd8);
        chk("stall_pend", 32'(dut.r_pend), 32'hF00);
        evt_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 12 && guard < 40) begin
            if (evt_valid) begin
                chk($sformatf("drain_id%0d", n), 32'(evt_id), 32'(n));
                n++;
            end
            tick();
            guard++;
        end
        chk("drain_count", 32'(n), 32'd12);
        chk("drain_valid", 32'(evt_valid), 32'd0);
        chk("drain_pend", 32'(dut.r_pend), 32'd0);

        // Overflow accounting with grants disabled.
        arb_en = 1'b0;
        pulse(12'h020);
        chk("ovf_first", 32'(ovf_cnt), 32'd0);
        pulse(12'h020);
        chk("ovf_sticky5", 32'(ovf_sticky), 32'h020);
        chk("ovf_cnt1", 32'(ovf_cnt), 32'd1);
        chk("ovf_nogrant", 32'(evt_valid), 32'd0);
        ovf_clr = 1'b1;
        tick();
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);
        chk("clr_cnt", 32'(ovf_cnt), 32'd0);
        done_pd = 12'h020;
        tick();
        done_pd = '0;
        ovf_clr = 1'b0;
        chk("clrwin_sticky", 32'(ovf_sticky), 32'd0);
        chk("clrwin_cnt", 32'(ovf_cnt), 32'd0);
        pulse(12'h001);
        pulse(12'h021);
        chk("multi_cnt", 32'(ovf_cnt), 32'd2);
        chk("multi_sticky", 32'(ovf_sticky), 32'h021);

        // Saturation: 12 losses per cycle.
        ovf_clr = 1'b1;
        pulse(12'hFFF);
        ovf_clr = 1'b0;
        chk("sat_start", 32'(ovf_cnt), 32'd0);
        repeat (21) pulse(12'hFFF);
        chk("sat_252", 32'(ovf_cnt), 32'd252);
        pulse(12'hFFF);
        chk("sat_255", 32'(ovf_cnt), 32'd255);
        pulse(12'hFFF);
        chk("sat_hold", 32'(ovf_cnt), 32'd255);
        chk("sat_sticky", 32'(ovf_sticky), 32'hFFF);
        flush_all();
        chk("flush_pend", 32'(dut.r_pend), 32'd0);
        chk("flush_keeps_ovf", 32'(ovf_cnt), 32'd255);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Flush with three queued and a simultaneous pulse.
        arb_en = 1'b1;
        evt_ready = 1'b0;
        pulse(12'h007);
        repeat (3) tick();
        chk("pre_flush_cnt", 32'(fifo_cnt), 32'd3);
        evt_flush = 1'b1;
        done_pd = 12'h800;
        tick();
        evt_flush = 1'b0;
        done_pd = '0;
        chk("fl_cnt", 32'(fifo_cnt), 32'd0);
        chk("fl_valid", 32'(evt_valid), 32'd0);
        chk("fl_pend", 32'(dut.r_pend), 32'd0);
        chk("fl_ovf", 32'(ovf_cnt), 32'd0);

        // Drain continues with arb_en low.
        pulse(12'h003);
        repeat (2) tick();
        chk("dr_cnt2", 32'(fifo_cnt), 32'd2);
        arb_en = 1'b0;
        pulse(12'h010);
        chk("dr_hold_cnt", 32'(fifo_cnt), 32'd2);
        evt_ready = 1'b1;
        tick();
        chk("dr_cnt1", 32'(fifo_cnt), 32'd1);
        chk("dr_id1", 32'(evt_id), 32'd1);
        tick();
        chk("dr_empty", 32'(evt_valid), 32'd0);
        chk("dr_pend", 32'(dut.r_pend), 32'h010);
        evt_ready = 1'b0;
        arb_en = 1'b1;
        tick();
        chk("dr_resume_id", 32'(evt_id), 32'd4);
        flush_all();

        // Pulse on the grant cycle re-arms the source without a loss.
        pulse(12'h008);
        pulse(12'h008);
        chk("rg_cnt1", 32'(fifo_cnt), 32'd1);
        chk("rg_pend", 32'(dut.r_pend), 32'h008);
        chk("rg_ovf", 32'(ovf_cnt), 32'd0);
        chk("rg_sticky", 32'(ovf_sticky), 32'd0);
        tick();
        chk("rg_cnt2", 32'(fifo_cnt), 32'd2);
        evt_ready = 1'b1;
        chk("rg_id_a", 32'(evt_id), 32'd3);
        tick();
        chk("rg_valid_b", 32'(evt_valid), 32'd1);
        chk("rg_id_b", 32'(evt_id), 32'd3);
        tick();
        chk("rg_done", 32'(evt_valid), 32'd0);

        // Asynchronous reset mid-operation.
        evt_ready = 1'b0;
        pulse(12'h0F0);
        repeat (3) tick();
        chk("ar_pre_cnt", 32'(fifo_cnt), 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("ar_valid", 32'(evt_valid), 32'd0);
        chk("ar_id", 32'(evt_id), 32'd0);
        chk("ar_ts", 32'(evt_ts), 32'd0);
        chk("ar_cnt", 32'(fifo_cnt), 32'd0);
        chk("ar_pend", 32'(dut.r_pend), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("ar_after_valid", 32'(evt_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
